// File: rtl/clk_iq_pkg.sv
// clk_iq_pkg: shared state codes and divider-output bit indices for the I/Q divider sequencer
// No ports; imported by clk_iq_chk and clk_iq_div_seq.
package clk_iq_pkg;
  localparam logic [2:0] IDLE = 3'd0, HOLD = 3'd1, SETTLE = 3'd2, CHECK = 3'd3, RUN = 3'd4, FAIL = 3'd5;
  localparam int CKO_I = 0, CKO_Q = 1, CKO_IB = 2, CKO_QB = 3;
endpackage

// File: rtl/clk_iq_div_seq_if.sv
// clk_iq_div_seq_if: control, feedback and status bundle between the system and the divider sequencer
// en/sync_req/cko_mon flow master->slave; div_rstn/cko_en/ready/err/retry_cnt flow slave->master.
interface clk_iq_div_seq_if;
  logic       en;
  logic       sync_req;
  logic [3:0] cko_mon;
  logic       div_rstn;
  logic       cko_en;
  logic       ready;
  logic       err;
  logic [1:0] retry_cnt;
  modport master(output en, sync_req, cko_mon, input div_rstn, cko_en, ready, err, retry_cnt);
  modport slave(input en, sync_req, cko_mon, output div_rstn, cko_en, ready, err, retry_cnt);
endinterface

// File: rtl/clk_iq_chk.sv
// clk_iq_chk: compares the divider outputs against the expected phase and counts consecutive good samples
// i_cki/i_rst_n clock and active-low reset; i_cko divider outputs; i_ph expected I level;
// i_act counting enable; o_good sample matches; o_done this good sample completes the run of CHK_CYC.
module clk_iq_chk #(
  parameter int CHK_CYC = 16
) (
  input  logic       i_cki,
  input  logic       i_rst_n,
  input  logic [3:0] i_cko,
  input  logic       i_ph,
  input  logic       i_act,
  output logic       o_good,
  output logic       o_done
);
  import clk_iq_pkg::*;
  localparam int CW = $clog2(CHK_CYC);
  logic [CW-1:0] r_cnt;
  assign o_good = i_cko[CKO_I] == i_ph && i_cko[CKO_Q] == i_cko[CKO_I] &&
                  i_cko[CKO_IB] == !i_cko[CKO_I] && i_cko[CKO_QB] == !i_cko[CKO_Q];
  assign o_done = o_good && r_cnt == CW'(CHK_CYC - 1);
  always_ff @(posedge i_cki or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= (i_act && o_good) ? r_cnt + 1'b1 : '0;
endmodule

// File: rtl/clk_iq_div_seq.sv
// clk_iq_div_seq: start-up, alignment and health sequencer for the /2 I/Q clock divider
// i_cki divider input clock; i_rstn async active-low reset (release synchronised to i_cki);
// bus.slave carries en/sync_req/cko_mon in and div_rstn/cko_en/ready/err/retry_cnt out, all registered.
module clk_iq_div_seq #(
  parameter int SETTLE_CYC = 8,
  parameter int CHK_CYC    = 16,
  parameter int MAX_RETRY  = 3
) (
  input logic             i_cki,
  input logic             i_rstn,
  clk_iq_div_seq_if.slave bus
);
  import clk_iq_pkg::*;
  localparam int SW = $clog2(SETTLE_CYC);
  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [2:0]    r_state, w_nxt, w_retry_st;
  logic [SW-1:0] r_scnt;
  logic [1:0]    r_retry;
  logic          r_ph, r_div_rstn, r_cko_en, r_ready, r_err;
  logic          w_good, w_done, w_bad;
  always_ff @(posedge i_cki or negedge i_rstn)
    if (!i_rstn) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  clk_iq_chk #(.CHK_CYC(CHK_CYC)) u_chk (
    .i_cki  (i_cki),
    .i_rst_n(w_rst_n),
    .i_cko  (bus.cko_mon),
    .i_ph   (r_ph),
    .i_act  (r_state == CHECK),
    .o_good (w_good),
    .o_done (w_done)
  );
  assign w_retry_st = (r_retry == 2'(MAX_RETRY)) ? FAIL : HOLD;
  assign w_bad      = (r_state == CHECK || r_state == RUN) && !w_good;
  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      IDLE:    w_nxt = HOLD;
      HOLD:    w_nxt = bus.sync_req ? SETTLE : HOLD;
      SETTLE:  w_nxt = (r_scnt == SW'(SETTLE_CYC - 1)) ? CHECK : SETTLE;
      CHECK:   w_nxt = !w_good ? w_retry_st : w_done ? RUN : CHECK;
      RUN:     w_nxt = !w_good ? w_retry_st : RUN;
      FAIL:    w_nxt = FAIL;
      default: w_nxt = IDLE;
    endcase
    if (!bus.en) w_nxt = IDLE;
  end
  // Outputs are decoded from the next state so they change on the same edge as the transition.
  // r_ph holds the expected I level for the coming edge: 0 for the first edge the divider runs.
  always_ff @(posedge i_cki or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_scnt     <= '0;
      r_retry    <= '0;
      r_ph       <= 1'b0;
      r_div_rstn <= 1'b0;
      r_cko_en   <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_scnt     <= (r_state == SETTLE) ? r_scnt + 1'b1 : '0;
      r_retry    <= (w_nxt == IDLE) ? '0 : (w_bad && r_retry != 2'(MAX_RETRY)) ? r_retry + 1'b1 : r_retry;
      r_ph       <= r_div_rstn & ~r_ph;
      r_div_rstn <= w_nxt == SETTLE || w_nxt == CHECK || w_nxt == RUN;
      r_cko_en   <= w_nxt == RUN;
      r_ready    <= w_nxt == RUN;
      r_err      <= w_nxt == FAIL;
    end
  assign bus.div_rstn  = r_div_rstn;
  assign bus.cko_en    = r_cko_en;
  assign bus.ready     = r_ready;
  assign bus.err       = r_err;
  assign bus.retry_cnt = r_retry;
endmodule

// File: tb/tb_clk_iq_div_seq.sv
// tb_clk_iq_div_seq: directed vectors against an ideal /2 divider model with injectable faults
module tb_clk_iq_div_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  clk_iq_div_seq_if bus();
  clk_iq_div_seq #(.SETTLE_CYC(8), .CHK_CYC(16), .MAX_RETRY(3)) dut (
    .i_cki (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );
  // Divider model: I held at init_i while in reset, toggles every edge once released.
  logic r_i = 1'b0, init_i = 1'b0, qs = 1'b0, ibf = 1'b0;
  always @(posedge clk) r_i <= bus.div_rstn ? ~r_i : init_i;
  assign bus.cko_mon = {~r_i, ibf ? r_i : ~r_i, qs ? 1'b0 : r_i, r_i};
  int total = 0, bad = 0;
  typedef struct {
    string      name;
    int         n;
    bit         en, sync, ii, qs, ibf;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(string name, int n, bit en, bit sync, bit ii, bit q, bit ib, logic [5:0] exp);
    vec_t v;
    v.name = name; v.n = n; v.en = en; v.sync = sync; v.ii = ii; v.qs = q; v.ibf = ib; v.exp = exp;
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // exp = {div_rstn, cko_en, ready, err, retry_cnt}
  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {bus.div_rstn, bus.cko_en, bus.ready, bus.err, bus.retry_cnt};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.sync_req = 1'b0;
    vecs.push_back(mk("idle_to_hold",   1, 1, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("sync_hold",      1, 1, 1, 0, 0, 0, 6'b100000));
    vecs.push_back(mk("settle",         8, 1, 0, 0, 0, 0, 6'b100000));
    vecs.push_back(mk("check_15",      15, 1, 0, 0, 0, 0, 6'b100000));
    vecs.push_back(mk("run_entry",      1, 1, 0, 0, 0, 0, 6'b111000));
    vecs.push_back(mk("run_sync_ign",  10, 1, 1, 0, 0, 0, 6'b111000));
    vecs.push_back(mk("run_loss",       1, 1, 0, 0, 0, 1, 6'b000001));
    vecs.push_back(mk("hold_wait",      5, 1, 0, 0, 0, 0, 6'b000001));
    vecs.push_back(mk("en_off",         1, 0, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("hold2",          1, 1, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("sync_ph",        1, 1, 1, 1, 0, 0, 6'b100000));
    vecs.push_back(mk("settle_ph",      8, 1, 0, 1, 0, 0, 6'b100000));
    vecs.push_back(mk("ph_fault",       1, 1, 0, 1, 0, 0, 6'b000001));
    vecs.push_back(mk("resync",         1, 1, 1, 0, 0, 0, 6'b100001));
    vecs.push_back(mk("run_after_ph",  24, 1, 0, 0, 0, 0, 6'b111001));
    vecs.push_back(mk("en_off2",        1, 0, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("hold3",          1, 1, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("sync_q",         1, 1, 1, 0, 1, 0, 6'b100000));
    vecs.push_back(mk("settle_q",       8, 1, 0, 0, 1, 0, 6'b100000));
    vecs.push_back(mk("q_first_good",   1, 1, 0, 0, 1, 0, 6'b100000));
    vecs.push_back(mk("q_bad1",         1, 1, 0, 0, 1, 0, 6'b000001));
    vecs.push_back(mk("sync_r2",        1, 1, 1, 0, 1, 0, 6'b100001));
    vecs.push_back(mk("q_bad2",        10, 1, 0, 0, 1, 0, 6'b000010));
    vecs.push_back(mk("sync_r3",        1, 1, 1, 0, 1, 0, 6'b100010));
    vecs.push_back(mk("q_bad3",        10, 1, 0, 0, 1, 0, 6'b000011));
    vecs.push_back(mk("sync_r4",        1, 1, 1, 0, 1, 0, 6'b100011));
    vecs.push_back(mk("q_fail",        10, 1, 0, 0, 1, 0, 6'b000111));
    vecs.push_back(mk("fail_stay",      3, 1, 1, 0, 1, 0, 6'b000111));
    vecs.push_back(mk("fail_clear",     1, 0, 0, 0, 0, 0, 6'b000000));
    repeat (3) tick;
    chk("reset_values", 6'b000000);
    rstn = 1'b1;
    repeat (3) tick;
    chk("post_reset_idle", 6'b000000);
    foreach (vecs[k]) begin
      bus.en = vecs[k].en;
      init_i = vecs[k].ii;
      qs = vecs[k].qs;
      ibf = vecs[k].ibf;
      bus.sync_req = vecs[k].sync;
      tick;
      bus.sync_req = 1'b0;
      repeat (vecs[k].n - 1) tick;
      chk(vecs[k].name, vecs[k].exp);
    end
    bus.en = 1'b1;
    tick;
    bus.en = 1'b0;
    bus.sync_req = 1'b1;
    tick;
    bus.sync_req = 1'b0;
    chk("en_off_beats_sync", 6'b000000);
    bus.en = 1'b1;
    repeat (4) tick;
    chk("no_settle_after_abort", 6'b000000);
    bus.sync_req = 1'b1;
    tick;
    bus.sync_req = 1'b0;
    repeat (10) tick;
    chk("check_live", 6'b100000);
    #2 rstn = 1'b0;
    #1 chk("async_reset_mid_check", 6'b000000);
    tick;
    rstn = 1'b1;
    repeat (3) tick;
    chk("hold_after_release", 6'b000000);
    bus.sync_req = 1'b1;
    tick;
    bus.sync_req = 1'b0;
    chk("sync_after_release", 6'b100000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_iq_div_seq.md
# clk_iq_div_seq

Start-up and alignment sequencer for the /2 I/Q clock divider. Holds the divider in reset, releases it on a system sync pulse so the I clock phase is deterministic, and checks the four divider outputs (I, Q, ~I, ~Q) for correct toggling and phase. After the check passes it enables the downstream clock gate. It retries a bounded number of times, then latches an error. Runs on the divider's input clock, next to the divider in the clock-generation slice.

## Interface
- SETTLE_CYC, 8, cycles after divider reset release before checking starts (≥2)
- CHK_CYC, 16, consecutive good samples required before RUN (≥2)
- MAX_RETRY, 3, retries allowed before FAIL (1..3)
- cki  in  1  input clock of the divider; all logic on posedge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  level; 1 = bring up divider, 0 = return to IDLE
- sync_req  in  1  single-cycle pulse, alignment event
- cko_mon  in  4  divider outputs fed back: [0] I, [1] Q, [2] ~I, [3] ~Q
- div_rstn  out  1  registered active-low reset to the divider
- cko_en  out  1  downstream clock-gate enable
- ready  out  1  divider aligned and verified
- err  out  1  sticky failure flag
- retry_cnt  out  2  retries used since leaving IDLE

## Operation
- Reset values: state IDLE; div_rstn=0, cko_en=0, ready=0, err=0, retry_cnt=0.
- IDLE: div_rstn=0 and retry_cnt cleared. en=1 → HOLD.
- HOLD: div_rstn=0. sync_req=1 → SETTLE, with div_rstn=1 registered on the same edge.
- SETTLE: count SETTLE_CYC cycles → CHECK. No checking in this state.
- CHECK: at every edge, sample cko_mon against the expected phase bit ph. A sample is good when:
  - I == ph
  - Q == I
  - ~I == !I
  - ~Q == !Q
- CHECK: after CHK_CYC consecutive good samples → RUN. Any bad sample → retry.
- RUN: cko_en=1, ready=1. Monitoring continues. A bad sample → retry. sync_req is ignored.
- Retry: go to HOLD with div_rstn=0, cko_en=0, ready=0, and retry_cnt+1. If retry_cnt==MAX_RETRY already → FAIL instead; retry_cnt saturates.
- FAIL: div_rstn=0, cko_en=0, err=1. Stays until en=0 → IDLE. IDLE clears err.
- en=0 in any state → IDLE on the next edge. This overrides sync_req and check results on the same edge.
- ph: cleared on the first edge at which div_rstn is 1, toggles every edge after that.

## Timing
- sync_req sampled at edge t in HOLD: div_rstn is 1 after t.
- Edge t+1 is the phase reference: expected I sample 0. Expected I at edge t+1+n = n mod 2.
- CHECK samples edges t+1+SETTLE_CYC through t+SETTLE_CYC+CHK_CYC.
- ready and cko_en are 1 after edge t+SETTLE_CYC+CHK_CYC.
- A bad sample at edge k: div_rstn, cko_en and ready are 0 after edge k.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous rstn mid-operation: all outputs go to reset values immediately. Release is synchronous to cki through the standard reset synchronizer.

## Structure
- Shared package clk_iq_pkg holds:
  - state enum: IDLE, HOLD, SETTLE, CHECK, RUN, FAIL
  - cko index constants: CKO_I=0, CKO_Q=1, CKO_IB=2, CKO_QB=3
- Sub-module clk_iq_chk: combinational sample-vs-ph comparator producing a good flag, plus the consecutive-good counter. Sequencer FSM, settle counter, retry counter and ph stay in the top level.

## Test plan
- Nominal: en=1, sync_req at edge 10, ideal /2 divider model → div_rstn=1 after edge 10; ready=1 after edge 34 (SETTLE_CYC=8, CHK_CYC=16); retry_cnt=0.
- Phase fault: divider model initialised with I=1 → first CHECK sample mismatches; HOLD; retry_cnt=1. Next sync_req with correct model → ready asserts.
- Persistent fault: Q stuck at 0 → retries 1, 2, 3, then FAIL with err=1 and cko_en=0. en=0 → IDLE; err=0, retry_cnt=0.
- Loss in RUN: force ~I==I for one cycle after ready → ready and cko_en drop after that edge; HOLD; retry_cnt=1.
- en=0 on the same edge as sync_req in HOLD → IDLE; div_rstn stays 0.
- rstn asserted during CHECK → outputs 0 immediately. After release, state is IDLE; with en=1 held, HOLD on the next edge.
